// File: rtl/ha1588_bus_arb.sv
// Two-master round-robin arbiter and strobe sequencer for the ha1588 register bus.
// Supports lockable ownership for atomic multi-register sequences, with an idle timeout.
module ha1588_bus_arb #(
    parameter int RD_LAT       = 2,
    parameter int LOCK_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        m0_req,
    input  logic        m0_wr,
    input  logic [7:0]  m0_addr,
    input  logic [31:0] m0_wdata,
    input  logic        m0_lock,
    output logic        m0_ack,
    output logic [31:0] m0_rdata,
    input  logic        m1_req,
    input  logic        m1_wr,
    input  logic [7:0]  m1_addr,
    input  logic [31:0] m1_wdata,
    input  logic        m1_lock,
    output logic        m1_ack,
    output logic [31:0] m1_rdata,
    output logic        wr_out,
    output logic        rd_out,
    output logic [7:0]  addr_out,
    output logic [31:0] data_out,
    input  logic [31:0] data_in,
    output logic        lock_err
);

    localparam int IDLE_W = $clog2(LOCK_TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, ACK} state_t;

    state_t             state, state_nxt;
    logic               gnt;
    logic               lat_wr;
    logic               lat_lock;
    logic [7:0]         lat_addr;
    logic [31:0]        lat_wdata;
    logic [3:0]         cnt;
    logic               rr;
    logic               owner_vld;
    logic               owner;
    logic [IDLE_W-1:0]  idle_cnt;

    logic               grant_vld;
    logic               grant_id;
    logic               owner_req;
    logic               timeout;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        grant_vld = 1'b0;
        grant_id  = 1'b0;
        timeout   = 1'b0;
        owner_req = owner ? m1_req : m0_req;
        wr_out    = 1'b0;
        rd_out    = 1'b0;
        m0_ack    = 1'b0;
        m1_ack    = 1'b0;
        addr_out  = lat_addr;
        data_out  = lat_wdata;

        case (state)
            IDLE: begin
                // While locked, only the owner may win; its silence runs the timeout.
                if (owner_vld) begin
                    grant_vld = owner_req;
                    grant_id  = owner;
                    timeout   = !owner_req && (idle_cnt == IDLE_W'(LOCK_TIMEOUT - 1));
                end else if (m0_req && m1_req) begin
                    grant_vld = 1'b1;
                    grant_id  = rr;
                end else if (m0_req || m1_req) begin
                    grant_vld = 1'b1;
                    grant_id  = !m0_req;
                end
                if (grant_vld) begin
                    state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                wr_out    = lat_wr;
                rd_out    = !lat_wr;
                state_nxt = lat_wr ? ACK : WAIT;
            end
            WAIT: begin
                if (cnt == 4'(RD_LAT)) begin
                    state_nxt = ACK;
                end
            end
            ACK: begin
                m0_ack    = !gnt;
                m1_ack    = gnt;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            gnt       <= 1'b0;
            lat_wr    <= 1'b0;
            lat_lock  <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
            cnt       <= '0;
            rr        <= 1'b0;
            owner_vld <= 1'b0;
            owner     <= 1'b0;
            idle_cnt  <= '0;
            lock_err  <= 1'b0;
            m0_rdata  <= '0;
            m1_rdata  <= '0;
        end else begin
            if (grant_vld) begin
                gnt       <= grant_id;
                lat_wr    <= grant_id ? m1_wr    : m0_wr;
                lat_lock  <= grant_id ? m1_lock  : m0_lock;
                lat_addr  <= grant_id ? m1_addr  : m0_addr;
                lat_wdata <= grant_id ? m1_wdata : m0_wdata;
                idle_cnt  <= '0;
            end else if (state == IDLE && owner_vld) begin
                if (timeout) begin
                    owner_vld <= 1'b0;
                    lock_err  <= 1'b1;
                    idle_cnt  <= '0;
                end else begin
                    idle_cnt  <= idle_cnt + IDLE_W'(1);
                end
            end

            case (state)
                ISSUE: cnt <= 4'd1;
                WAIT: begin
                    cnt <= cnt + 4'd1;
                    if (cnt == 4'(RD_LAT)) begin
                        if (gnt) begin
                            m1_rdata <= data_in;
                        end else begin
                            m0_rdata <= data_in;
                        end
                    end
                end
                ACK: begin
                    rr        <= !gnt;
                    owner_vld <= lat_lock;
                    owner     <= gnt;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ha1588_bus_arb.sv
// Directed bench for ha1588_bus_arb with a small ha1588 register-file model
// answering reads RD_LAT cycles after the rd strobe.
module tb_ha1588_bus_arb;

    localparam int RD_LAT       = 2;
    localparam int LOCK_TIMEOUT = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        m0_req = 1'b0, m0_wr = 1'b0, m0_lock = 1'b0;
    logic [7:0]  m0_addr = '0;
    logic [31:0] m0_wdata = '0;
    logic        m0_ack;
    logic [31:0] m0_rdata;
    logic        m1_req = 1'b0, m1_wr = 1'b0, m1_lock = 1'b0;
    logic [7:0]  m1_addr = '0;
    logic [31:0] m1_wdata = '0;
    logic        m1_ack;
    logic [31:0] m1_rdata;
    logic        wr_out, rd_out;
    logic [7:0]  addr_out;
    logic [31:0] data_out;
    logic [31:0] data_in = 32'hBADBAD00;
    logic        lock_err;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    ha1588_bus_arb #(.RD_LAT(RD_LAT), .LOCK_TIMEOUT(LOCK_TIMEOUT)) dut (
        .clk(clk), .rst(rst),
        .m0_req(m0_req), .m0_wr(m0_wr), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_lock(m0_lock), .m0_ack(m0_ack), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_wr(m1_wr), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_lock(m1_lock), .m1_ack(m1_ack), .m1_rdata(m1_rdata),
        .wr_out(wr_out), .rd_out(rd_out), .addr_out(addr_out), .data_out(data_out),
        .data_in(data_in), .lock_err(lock_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Register-file model of the ha1588 core.
    logic [31:0] mem [256];
    logic        loaded = 1'b0;
    int          rd_k = 0;
    logic [31:0] rd_val = '0;

    always @(negedge clk) begin
        if (!loaded) begin
            for (int a = 0; a < 256; a++) mem[a] <= 32'h0;
            mem[8'h20] <= 32'h12345678;
            mem[8'h0C] <= 32'hC0C0C0C0;
            for (int a = 0; a < 4; a++) mem[8'h30 + a] <= 32'h30000000 + a;
            loaded <= 1'b1;
        end else begin
            data_in <= 32'hBADBAD00;
            if (rd_k != 0) begin
                rd_k <= rd_k - 1;
                if (rd_k == 1) data_in <= rd_val;
            end
            if (rd_out) begin
                rd_k   <= RD_LAT;
                rd_val <= mem[addr_out];
            end
            if (wr_out) mem[addr_out] <= data_out;
        end
    end

    // Bus monitor: strobe log, ack order, lock_err rise.
    int          stb_cyc[$];
    logic        stb_wr[$];
    logic [7:0]  stb_addr[$];
    logic [31:0] stb_data[$];
    logic        ack_who[$];
    int          n_ack0 = 0, n_ack1 = 0;
    logic        both_stb = 1'b0;
    logic        lerr_prev = 1'b0;
    int          lerr_cyc = -1;

    always @(negedge clk) begin
        if (wr_out || rd_out) begin
            stb_cyc.push_back(cyc);
            stb_wr.push_back(wr_out);
            stb_addr.push_back(addr_out);
            stb_data.push_back(data_out);
        end
        if (wr_out && rd_out) both_stb <= 1'b1;
        if (m0_ack) begin ack_who.push_back(1'b0); n_ack0 <= n_ack0 + 1; end
        if (m1_ack) begin ack_who.push_back(1'b1); n_ack1 <= n_ack1 + 1; end
        if (lock_err && !lerr_prev) lerr_cyc <= cyc;
        lerr_prev <= lock_err;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    // One master transaction; called at posedge+1, returns at posedge+1 after the ack.
    task automatic txn(input bit m, input bit wr, input logic [7:0] addr, input logic [31:0] wd,
                       input bit lk, output int ack_c, output logic [31:0] rd);
        bit seen = 1'b0;
        ack_c = -1;
        rd    = '0;
        if (m) begin
            m1_req = 1'b1; m1_wr = wr; m1_addr = addr; m1_wdata = wd; m1_lock = lk;
        end else begin
            m0_req = 1'b1; m0_wr = wr; m0_addr = addr; m0_wdata = wd; m0_lock = lk;
        end
        for (int i = 0; i < 64 && !seen; i++) begin
            @(negedge clk);
            if ((m && m1_ack) || (!m && m0_ack)) begin
                seen  = 1'b1;
                ack_c = cyc;
                rd    = m ? m1_rdata : m0_rdata;
            end
        end
        @(posedge clk); #1;
        if (m) m1_req = 1'b0; else m0_req = 1'b0;
        check(m ? "m1_ack_seen" : "m0_ack_seen", 32'(seen), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got time limit reached, expected bench completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int t, a0, a1, a2, a3, base, sidx, n1;
        logic [31:0] r;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_wr_out", 32'(wr_out), 0);
        check("rst_rd_out", 32'(rd_out), 0);
        check("rst_addr_out", 32'(addr_out), 0);
        check("rst_data_out", data_out, 0);
        check("rst_acks", 32'({m0_ack, m1_ack}), 0);
        check("rst_rdata", m0_rdata | m1_rdata, 0);
        check("rst_lock_err", 32'(lock_err), 0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;

        // m0 write
        t = cyc; sidx = stb_cyc.size(); n1 = n_ack1;
        txn(0, 1, 8'h10, 32'hDEADBEEF, 0, a0, r);
        check("s1_nstb", stb_cyc.size() - sidx, 1);
        check("s1_stb_cyc", stb_cyc[sidx], t + 1);
        check("s1_stb_wr", 32'(stb_wr[sidx]), 1);
        check("s1_addr", 32'(stb_addr[sidx]), 32'h10);
        check("s1_data", stb_data[sidx], 32'hDEADBEEF);
        check("s1_ack_cyc", a0, t + 2);
        check("s1_m1_ack", n_ack1 - n1, 0);

        // m1 read
        t = cyc; sidx = stb_cyc.size();
        txn(1, 0, 8'h20, 32'h0, 0, a1, r);
        check("s2_nstb", stb_cyc.size() - sidx, 1);
        check("s2_stb_cyc", stb_cyc[sidx], t + 1);
        check("s2_stb_rd", 32'(stb_wr[sidx]), 0);
        check("s2_addr", 32'(stb_addr[sidx]), 32'h20);
        check("s2_ack_cyc", a1, t + 4);
        check("s2_rdata", r, 32'h12345678);
        repeat (3) @(negedge clk);
        check("s2_rdata_held", m1_rdata, 32'h12345678);
        check("s2_m0_rdata", m0_rdata, 0);
        @(posedge clk); #1;

        // Both masters continuously, unlocked: strict alternation
        base = ack_who.size();
        fork
            begin
                int ac; logic [31:0] rr;
                for (int i = 0; i < 4; i++) txn(0, 1, 8'(8'h40 + i), 32'h1000 + i, 0, ac, rr);
            end
            begin
                int ac; logic [31:0] rr;
                for (int i = 0; i < 4; i++) begin
                    txn(1, 0, 8'(8'h30 + i), 32'h0, 0, ac, rr);
                    check("s3_m1_rdata", rr, 32'h30000000 + i);
                end
            end
        join
        check("s3_nacks", ack_who.size() - base, 8);
        for (int k = 0; k < 8; k++) check("s3_order", 32'(ack_who[base + k]), k % 2);
        check("s3_one_strobe", 32'(both_stb), 0);

        // m1 locked sequence while m0 requests throughout
        base = ack_who.size();
        fork
            begin
                txn(1, 1, 8'h00, 32'hA5A5A5A5, 1, a1, r);
                txn(1, 0, 8'h0C, 32'h0, 1, a2, r);
                check("s4_rd0c", r, 32'hC0C0C0C0);
                txn(1, 0, 8'h10, 32'h0, 0, a3, r);
                check("s4_rd10", r, 32'hDEADBEEF);
            end
            begin
                int ac; logic [31:0] rr;
                @(posedge clk); #1;
                txn(0, 1, 8'h50, 32'h5050, 0, ac, rr);
                a0 = ac;
            end
        join
        check("s4_nacks", ack_who.size() - base, 4);
        for (int k = 0; k < 4; k++) check("s4_order", 32'(ack_who[base + k]), (k < 3) ? 1 : 0);
        check("s4_m0_after", 32'(a0 > a3), 1);

        // Lock timeout: m0 keeps the lock and goes silent
        txn(0, 1, 8'h60, 32'h6060, 1, a0, r);
        sidx = stb_cyc.size();
        txn(1, 1, 8'h61, 32'h6161, 0, a1, r);
        check("s5_lerr_cyc", lerr_cyc, a0 + 9);
        check("s5_m1_stb_cyc", stb_cyc[sidx], a0 + 10);
        check("s5_m1_ack_cyc", a1, a0 + 11);
        @(negedge clk);
        check("s5_lock_err_sticky", 32'(lock_err), 1);
        check("s5_one_strobe", 32'(both_stb), 0);
        @(posedge clk); #1;

        // Reset during m1 read WAIT
        n1 = n_ack1;
        m1_req = 1'b1; m1_wr = 1'b0; m1_addr = 8'h20; m1_wdata = 32'h0; m1_lock = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        m1_req = 1'b0;
        @(negedge clk);
        check("s6_strobes", 32'({wr_out, rd_out}), 0);
        check("s6_acks", 32'({m0_ack, m1_ack}), 0);
        check("s6_addr_out", 32'(addr_out), 0);
        check("s6_data_out", data_out, 0);
        check("s6_rdata", m0_rdata | m1_rdata, 0);
        check("s6_lock_err", 32'(lock_err), 0);
        @(posedge clk); #1;
        rst = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check("s6_no_m1_ack", n_ack1 - n1, 0);
        t = cyc;
        txn(0, 0, 8'h42, 32'h0, 0, a0, r);
        check("s6_m0_ack_cyc", a0, t + 4);
        check("s6_m0_rdata", r, 32'h00001002);
        check("s6_m1_rdata_kept", m1_rdata, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
